serial_frame_receiver: RTL

SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

---
 rtl/serial_pkg.sv | 17 +
 rtl/rx_out_buffer.sv | 54 +++++
 rtl/serial_frame_receiver.sv | 90 +++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame receiver.
// Holds the FSM state type, default width and parity modes.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } rx_state_t;

  localparam int DEF_WIDTH = 4;

  localparam bit PAR_NONE = 1'b0;
  localparam bit PAR_EVEN = 1'b1;

endpackage

// File: rtl/rx_out_buffer.sv
// One-entry output holding register with valid/ready and overrun pulse.
// Ports: i_load/i_data/i_perr in, out_ready in, out_* / overrun out.
module rx_out_buffer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_perr,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             par_err,
  output logic             overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_perr;
  logic             r_ovr;
  logic             w_take;

  // Slot is free if empty or being drained this same cycle.
  assign w_take = !r_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (i_load) begin
        if (w_take) begin
          r_data  <= i_data;
          r_perr  <= i_perr;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign par_err   = r_perr;
  assign overrun   = r_ovr;

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits MSB first, opt. parity.
// Ports: clk, reset, serial_in, bit_en, out_ready in; out_data, out_valid, par_err, overrun, busy out.
module serial_frame_receiver
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit PARITY_EN = PAR_EVEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             par_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rx_state_t        r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_perr;

  logic [WIDTH-1:0] w_shift_nxt;
  logic [CW-1:0]    w_last;
  logic             w_done;

  // Shift form that also works for WIDTH=1.
  assign w_shift_nxt = (r_shift << 1) | WIDTH'(serial_in);
  assign w_last      = CW'(WIDTH - 1);
  assign w_done      = (r_state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bit_en && serial_in) begin
            r_state <= ST_DATA;
            r_cnt   <= '0;
            r_perr  <= 1'b0;
          end
        end
        ST_DATA: begin
          if (bit_en) begin
            r_shift <= w_shift_nxt;
            r_cnt   <= r_cnt + CW'(1);
            if (r_cnt == w_last) begin
              r_state <= PARITY_EN ? ST_PARITY : ST_DONE;
            end
          end
        end
        ST_PARITY: begin
          if (bit_en) begin
            r_perr  <= serial_in ^ (^r_shift);
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);

  rx_out_buffer #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_done),
    .i_data   (r_shift),
    .i_perr   (r_perr),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .par_err  (par_err),
    .overrun  (overrun)
  );

endmodule
